// File: rtl/snake_round_ctrl_if.sv
// Bundles the round controller's strobes, button levels and datapath results.
// master = the side driving tick/buttons/results; slave = the controller itself.
interface snake_round_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               start;
  logic               pause;
  logic               hit1;
  logic               hit2;
  logic               eat1;
  logic               eat2;
  logic               step;
  logic               init_pos;
  logic               grow1;
  logic               grow2;
  logic               freeze;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [1:0]         count;
  logic [1:0]         winner;
  logic [2:0]         state;

  modport master (
    output tick, start, pause, hit1, hit2, eat1, eat2,
    input  step, init_pos, grow1, grow2, freeze,
    input  score1, score2, count, winner, state
  );

  modport slave (
    input  tick, start, pause, hit1, hit2, eat1, eat2,
    output step, init_pos, grow1, grow2, freeze,
    output score1, score2, count, winner, state
  );
endinterface

// File: rtl/snake_round_ctrl.sv
// Round/step sequencer for the two-player snake game: turns update ticks into
// step strobes, runs countdown/play/pause/over phases and keeps round scores.
module snake_round_ctrl #(
  parameter int TICKS_PER_STEP  = 4,
  parameter int COUNTDOWN_STEPS = 3,
  parameter int WIN_SCORE       = 5,
  parameter int SCORE_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  snake_round_ctrl_if.slave  bus
);

  localparam int TC_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TC_W-1:0]    TC_LAST    = TC_W'(TICKS_PER_STEP - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [1:0]         COUNT_LOAD = 2'(COUNTDOWN_STEPS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_COUNT  = 3'd2,
    S_PLAY   = 3'd3,
    S_EVAL   = 3'd4,
    S_PAUSED = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  state_t             r_state, w_state_next;
  logic [TC_W-1:0]    r_tc, w_tc_next, w_tc_inc;
  logic [1:0]         r_count, w_count_next;
  logic [SCORE_W-1:0] r_score1, w_score1_next, w_score1_inc;
  logic [SCORE_W-1:0] r_score2, w_score2_next, w_score2_inc;
  logic [1:0]         r_winner, w_winner_next;
  logic               r_step, w_step_next;
  logic               r_init_pos, w_init_pos_next;
  logic               r_grow1, w_grow1_next;
  logic               r_grow2, w_grow2_next;
  logic               r_freeze, w_freeze_next;
  logic               r_start_d, r_pause_d;
  logic               w_start_edge, w_pause_edge, w_boundary;

  // Edge registers reset high so a button held through reset needs a release first.
  assign w_start_edge = bus.start & ~r_start_d;
  assign w_pause_edge = bus.pause & ~r_pause_d;
  assign w_boundary   = bus.tick && (r_tc == TC_LAST);
  assign w_tc_inc     = w_boundary ? '0 : r_tc + 1'b1;
  assign w_score1_inc = r_score1 + 1'b1;
  assign w_score2_inc = r_score2 + 1'b1;

  always_comb begin
    w_state_next    = r_state;
    w_tc_next       = r_tc;
    w_count_next    = r_count;
    w_score1_next   = r_score1;
    w_score2_next   = r_score2;
    w_winner_next   = r_winner;
    w_step_next     = 1'b0;
    w_init_pos_next = 1'b0;
    w_grow1_next    = 1'b0;
    w_grow2_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tc_next = '0;
        if (w_start_edge) begin
          w_state_next  = S_INIT;
          w_score1_next = '0;
          w_score2_next = '0;
          w_winner_next = 2'b00;
        end
      end
      S_INIT: begin
        w_init_pos_next = 1'b1;
        w_count_next    = COUNT_LOAD;
        w_tc_next       = '0;
        w_state_next    = S_COUNT;
      end
      S_COUNT: begin
        if (bus.tick) w_tc_next = w_tc_inc;
        if (w_boundary) begin
          if (r_count <= 2'd1) begin
            w_count_next = 2'd0;
            w_state_next = S_PLAY;
          end else begin
            w_count_next = r_count - 2'd1;
          end
        end
      end
      S_PLAY: begin
        // A pause edge wins over a coincident boundary; tc is left untouched.
        if (w_pause_edge) begin
          w_state_next = S_PAUSED;
        end else begin
          if (bus.tick) w_tc_next = w_tc_inc;
          if (w_boundary) begin
            w_step_next  = 1'b1;
            w_state_next = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        if (bus.tick) w_tc_next = w_tc_inc;
        if (bus.hit1 && bus.hit2) begin
          w_state_next = S_INIT;
        end else if (bus.hit1) begin
          w_score2_next = w_score2_inc;
          if (w_score2_inc == WIN_VAL) begin
            w_state_next  = S_OVER;
            w_winner_next = 2'b10;
          end else begin
            w_state_next = S_INIT;
          end
        end else if (bus.hit2) begin
          w_score1_next = w_score1_inc;
          if (w_score1_inc == WIN_VAL) begin
            w_state_next  = S_OVER;
            w_winner_next = 2'b01;
          end else begin
            w_state_next = S_INIT;
          end
        end else begin
          w_grow1_next = bus.eat1;
          w_grow2_next = bus.eat2;
          w_state_next = S_PLAY;
        end
      end
      S_PAUSED: begin
        if (w_pause_edge) w_state_next = S_PLAY;
      end
      S_OVER: begin
        w_tc_next = '0;
        if (w_start_edge) begin
          w_state_next  = S_INIT;
          w_score1_next = '0;
          w_score2_next = '0;
          w_winner_next = 2'b00;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_freeze_next = !((w_state_next == S_PLAY) || (w_state_next == S_EVAL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tc       <= '0;
      r_count    <= 2'd0;
      r_score1   <= '0;
      r_score2   <= '0;
      r_winner   <= 2'b00;
      r_step     <= 1'b0;
      r_init_pos <= 1'b0;
      r_grow1    <= 1'b0;
      r_grow2    <= 1'b0;
      r_freeze   <= 1'b1;
      r_start_d  <= 1'b1;
      r_pause_d  <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_tc       <= w_tc_next;
      r_count    <= w_count_next;
      r_score1   <= w_score1_next;
      r_score2   <= w_score2_next;
      r_winner   <= w_winner_next;
      r_step     <= w_step_next;
      r_init_pos <= w_init_pos_next;
      r_grow1    <= w_grow1_next;
      r_grow2    <= w_grow2_next;
      r_freeze   <= w_freeze_next;
      r_start_d  <= bus.start;
      r_pause_d  <= bus.pause;
    end
  end

  assign bus.step     = r_step;
  assign bus.init_pos = r_init_pos;
  assign bus.grow1    = r_grow1;
  assign bus.grow2    = r_grow2;
  assign bus.freeze   = r_freeze;
  assign bus.score1   = r_score1;
  assign bus.score2   = r_score2;
  assign bus.count    = r_count;
  assign bus.winner   = r_winner;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_snake_round_ctrl.sv
// Directed walk through the round controller's phases, then random play,
// every cycle compared against a phase-level reference model.
module tb_snake_round_ctrl;

  localparam int TPS = 2;
  localparam int CD  = 3;
  localparam int WIN = 2;
  localparam int SW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  snake_round_ctrl_if #(.SCORE_W(SW)) bus ();

  snake_round_ctrl #(
    .TICKS_PER_STEP (TPS),
    .COUNTDOWN_STEPS(CD),
    .WIN_SCORE      (WIN),
    .SCORE_W        (SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step_seen = 0;
  int n_grow_both = 0;
  bit h1 = 0, h2 = 0, e1 = 0, e2 = 0, r_drv = 1;

  // Reference model: phase 0 idle, 1 init, 2 countdown, 3 play, 4 eval, 5 paused, 6 over
  int m_phase = 0, m_tc = 0, m_count = 0, m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_step = 0, m_init = 0, m_g1 = 0, m_g2 = 0;
  bit m_prev_start = 1, m_prev_pause = 1;

  task automatic model_step(input bit rs, input bit t, input bit s, input bit p,
                            input bit a1, input bit a2, input bit f1, input bit f2);
    bit se, pe, bnd;
    se = s && !m_prev_start;
    pe = p && !m_prev_pause;
    m_prev_start = s;
    m_prev_pause = p;
    m_step = 0; m_init = 0; m_g1 = 0; m_g2 = 0;
    if (rs) begin
      m_phase = 0; m_tc = 0; m_count = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_prev_start = 1; m_prev_pause = 1;
      return;
    end
    bnd = t && (m_tc == TPS - 1);
    case (m_phase)
      0, 6: if (se) begin m_phase = 1; m_s1 = 0; m_s2 = 0; m_win = 0; end
      1: begin m_init = 1; m_count = CD; m_tc = 0; m_phase = 2; end
      2: begin
        if (t) m_tc = (m_tc + 1) % TPS;
        if (bnd) begin
          m_count = m_count - 1;
          if (m_count == 0) m_phase = 3;
        end
      end
      3: begin
        if (pe) m_phase = 5;
        else begin
          if (t) m_tc = (m_tc + 1) % TPS;
          if (bnd) begin m_step = 1; m_phase = 4; end
        end
      end
      4: begin
        if (t) m_tc = (m_tc + 1) % TPS;
        if (a1 && a2) m_phase = 1;
        else if (a1 || a2) begin
          if (a1) m_s2++; else m_s1++;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_win = (m_s1 == WIN) ? 1 : 2;
            m_phase = 6;
          end else m_phase = 1;
        end else begin
          m_g1 = f1; m_g2 = f2; m_phase = 3;
        end
      end
      5: if (pe) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("step",     32'(bus.step),     32'(m_step));
    chk("init_pos", 32'(bus.init_pos), 32'(m_init));
    chk("grow1",    32'(bus.grow1),    32'(m_g1));
    chk("grow2",    32'(bus.grow2),    32'(m_g2));
    chk("freeze",   32'(bus.freeze),   32'(!(m_phase == 3 || m_phase == 4)));
    chk("score1",   32'(bus.score1),   32'(m_s1));
    chk("score2",   32'(bus.score2),   32'(m_s2));
    chk("count",    32'(bus.count),    32'(m_count));
    chk("winner",   32'(bus.winner),   32'(m_win));
    chk("state",    32'(bus.state),    32'(m_phase));
  endtask

  task automatic cyc(input bit t, input bit s, input bit p);
    rst = r_drv;
    bus.tick = t; bus.start = s; bus.pause = p;
    bus.hit1 = h1; bus.hit2 = h2; bus.eat1 = e1; bus.eat2 = e2;
    @(posedge clk);
    model_step(r_drv, t, s, p, h1, h2, e1, e2);
    #1;
    compare_all();
    if (bus.step === 1'b1) n_step_seen++;
    if (bus.grow1 === 1'b1 && bus.grow2 === 1'b1) n_grow_both++;
  endtask

  // One tick followed by four quiet cycles, n times.
  task automatic run_ticks(input int n, input bit p);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b0, p);
      for (int j = 0; j < 4; j++) cyc(1'b0, 1'b0, p);
    end
  endtask

  initial begin
    bus.tick = 0; bus.start = 0; bus.pause = 0;
    bus.hit1 = 0; bus.hit2 = 0; bus.eat1 = 0; bus.eat2 = 0;

    r_drv = 1;
    cyc(0, 0, 0); cyc(0, 0, 0);
    chk("rst_freeze", 32'(bus.freeze), 32'd1);
    chk("rst_state", 32'(bus.state), 32'd0);
    $display("txn reset state=%0d freeze=%0d", bus.state, bus.freeze);
    r_drv = 0;
    cyc(0, 0, 0);

    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("init_pulse", 32'(bus.init_pos), 32'd1);
    chk("count_load", 32'(bus.count), 32'd3);
    run_ticks(6, 0);
    chk("cd_state", 32'(bus.state), 32'd3);
    chk("cd_count", 32'(bus.count), 32'd0);
    chk("cd_freeze", 32'(bus.freeze), 32'd0);
    $display("txn countdown state=%0d count=%0d", bus.state, bus.count);

    n_step_seen = 0;
    run_ticks(2, 0);
    chk("one_step", 32'(n_step_seen), 32'd1);
    chk("play_scores", 32'(bus.score1 + bus.score2), 32'd0);
    $display("txn step steps=%0d state=%0d", n_step_seen, bus.state);

    e1 = 1; e2 = 1; n_grow_both = 0;
    run_ticks(2, 0);
    chk("grow_both", 32'(n_grow_both), 32'd1);
    e1 = 0; e2 = 0;
    $display("txn eat both grow_both=%0d", n_grow_both);

    h1 = 1; e2 = 1; n_grow_both = 0;
    run_ticks(2, 0);
    chk("hit1_score2", 32'(bus.score2), 32'd1);
    chk("hit1_grow2", 32'(bus.grow2), 32'd0);
    chk("hit1_state", 32'(bus.state), 32'd2);
    chk("hit1_count", 32'(bus.count), 32'd3);
    h1 = 0; e2 = 0;
    $display("txn hit1 score2=%0d state=%0d", bus.score2, bus.state);
    run_ticks(6, 0);

    h1 = 1; h2 = 1;
    run_ticks(2, 0);
    chk("draw_score1", 32'(bus.score1), 32'd0);
    chk("draw_score2", 32'(bus.score2), 32'd1);
    h1 = 0; h2 = 0;
    $display("txn draw scores=%0d/%0d", bus.score1, bus.score2);
    run_ticks(6, 0);

    run_ticks(1, 0);
    n_step_seen = 0;
    cyc(1, 0, 1);
    chk("pause_state", 32'(bus.state), 32'd5);
    run_ticks(10, 0);
    chk("pause_nostep", 32'(n_step_seen), 32'd0);
    chk("pause_hold", 32'(bus.state), 32'd5);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("resume_state", 32'(bus.state), 32'd3);
    cyc(1, 0, 0);
    chk("resume_step", 32'(bus.step), 32'd1);
    $display("txn pause/resume state=%0d step=%0d", bus.state, bus.step);
    for (int j = 0; j < 4; j++) cyc(0, 0, 0);

    h2 = 1;
    run_ticks(2, 0);
    run_ticks(6, 0);
    run_ticks(2, 0);
    chk("win_score1", 32'(bus.score1), 32'd2);
    chk("win_state", 32'(bus.state), 32'd6);
    chk("win_winner", 32'(bus.winner), 32'd1);
    h2 = 0;
    $display("txn game over winner=%0d score1=%0d", bus.winner, bus.score1);
    cyc(0, 1, 0);
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_scores", 32'(bus.score1 + bus.score2), 32'd0);
    cyc(0, 0, 0);
    $display("txn restart state=%0d", bus.state);

    begin
      bit rs = 0, rp = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) rs = ~rs;
        if ($urandom_range(0, 9) == 0) rp = ~rp;
        h1 = ($urandom_range(0, 7) == 0);
        h2 = ($urandom_range(0, 7) == 0);
        e1 = ($urandom_range(0, 2) == 0);
        e2 = ($urandom_range(0, 2) == 0);
        r_drv = ($urandom_range(0, 299) == 0);
        cyc($urandom_range(0, 2) == 0, rs, rp);
        if (i % 1000 == 999) $display("txn random block %0d done", i / 1000);
      end
    end
    r_drv = 0; h1 = 0; h2 = 0; e1 = 0; e2 = 0;

    r_drv = 1;
    cyc(0, 1, 0); cyc(0, 1, 0);
    r_drv = 0;
    for (int j = 0; j < 20; j++) cyc(0, 1, 0);
    chk("held_start_idle", 32'(bus.state), 32'd0);
    $display("txn start held through reset state=%0d", bus.state);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_round_ctrl.md
Name: snake_round_ctrl

Overview:
- Round and step sequencer for the two-player snake datapath: the two move units, the collision/food logic and the renderer.
- Converts the game-update tick into single-cycle step strobes and runs countdown, play, pause and game-over phases.
- Arbitrates simultaneous collision/eat results from both snakes and keeps per-player round scores.
- Sits between the update-clock divider and the move/snaketop blocks, all on one clock domain.

Parameters:
TICKS_PER_STEP, 4, update ticks per snake step (>=1)
COUNTDOWN_STEPS, 3, step periods shown as countdown before play (1..3)
WIN_SCORE, 5, round wins needed to end the game (1..2^SCORE_W-1)
SCORE_W, 4, score width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle game-update strobe
start  in  1  start/restart button level; rising edge detected internally
pause  in  1  pause button level; rising edge detected internally
hit1  in  1  snake 1 collided (wall/self/other); valid in EVAL
hit2  in  1  snake 2 collided; valid in EVAL
eat1  in  1  snake 1 head on food; valid in EVAL
eat2  in  1  snake 2 head on food; valid in EVAL
step  out  1  one-cycle strobe: advance both snakes
init_pos  out  1  one-cycle strobe: reload start positions and lengths
grow1  out  1  one-cycle strobe: lengthen snake 1
grow2  out  1  one-cycle strobe: lengthen snake 2
freeze  out  1  high except in PLAY/EVAL; gates movement
score1  out  SCORE_W  player 1 round wins
score2  out  SCORE_W  player 2 round wins
count  out  2  countdown value for display
winner  out  2  00 none, 01 P1, 10 P2; valid in OVER
state  out  3  IDLE=0 INIT=1 COUNT=2 PLAY=3 EVAL=4 PAUSED=5 OVER=6

Behaviour:
- Reset: state IDLE.
- Reset output values: step/init_pos/grow1/grow2 = 0, freeze = 1, scores = 0, count = 0, winner = 00.
- Reset also clears the tick counter and sets both button edge registers to 1. A button held through reset therefore must be released before it can register an edge.
- Outputs are registered. A strobe caused by a state entered at cycle N is high in cycle N+1 only.
- Tick counter tc (0..TICKS_PER_STEP-1):
  - Advances on tick in COUNT, PLAY and EVAL.
  - Holds in PAUSED.
  - Cleared in IDLE, INIT and OVER.
  - Boundary = tick while tc == TICKS_PER_STEP-1; tc wraps to 0.
- IDLE: start edge -> INIT; clear scores and winner.
- INIT (one cycle):
  - Assert init_pos next cycle.
  - Load count = COUNTDOWN_STEPS, clear tc.
  - -> COUNT.
- COUNT: on boundary, if count == 1 then count = 0 and -> PLAY; else count decrements.
- PLAY:
  - Pause edge -> PAUSED; this takes priority over a boundary in the same cycle, and the boundary tick is held.
  - Otherwise, on boundary: assert step next cycle and -> EVAL.
- EVAL: entered the cycle after the boundary; the datapath result is valid while step is high. Sample hit/eat once.
  - hit1 & hit2: draw, scores unchanged -> INIT.
  - hit1 only: score2 += 1.
  - hit2 only: score1 += 1.
  - After any score increment: if the new score == WIN_SCORE -> OVER, winner set; else -> INIT.
  - No hit: grow1 = eat1 and grow2 = eat2 next cycle (both may fire together) -> PLAY.
  - Any hit: eat inputs are ignored.
- PAUSED: pause edge -> PLAY, tc resumes from its held value. Start edge is ignored.
- OVER: start edge -> INIT with scores and winner cleared.
- Start edges in COUNT, PLAY, EVAL and PAUSED are ignored.
- freeze = 1 in IDLE, INIT, COUNT, PAUSED and OVER.
- Scores never exceed WIN_SCORE; no wrap is possible.
- rst asserted in any state returns to reset values on the next edge, including mid-EVAL. Strobes pending for the next cycle are dropped.

Test Plan:
- TICKS_PER_STEP=2, COUNTDOWN_STEPS=3. Start pulse, then ticks every 5 cycles -> init_pos one cycle; count goes 3,2,1 then 0 on the 6th tick; state -> PLAY; freeze falls.
- In PLAY, two ticks -> exactly one step pulse one cycle after the 2nd tick; state 4 for one cycle, then 3. With no hit/eat, scores stay 0.
- EVAL with eat1=1 and eat2=1, no hit -> grow1 and grow2 both high in the same single cycle; back to PLAY.
- EVAL with hit1=1 and eat2=1 -> score2=1, grow2 stays 0, init_pos pulses, count reloads to 3. Repeat with hit1=hit2=1 -> scores unchanged.
- Pause edge coincident with a boundary tick -> no step, state PAUSED, tc held. Ten ticks while paused -> no step. Pause edge -> PLAY; the next tick gives a boundary.
- WIN_SCORE=2, two rounds with hit2 only -> score1=2, state OVER, winner=01. Start held through reset and never released -> stays IDLE. Start edge in OVER -> scores 0, INIT.
